// File: rtl/mult_sweep_sequencer.sv
// Exhaustive self-test sequencer for a WIDTH x WIDTH multiplier: sweeps every
// operand pair, resets/starts the multiplier per pair and checks the product.
module mult_sweep_sequencer #(
  parameter int WIDTH       = 4,
  parameter int WAIT_CYCLES = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [2*WIDTH-1:0] prod,
  output logic               mul_rst,
  output logic               mul_start,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   first_err_a,
  output logic [WIDTH-1:0]   first_err_b
);

  localparam int PW = 2 * WIDTH;
  localparam int EW = 2 * WIDTH + 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WIDTH-1:0] OP_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] OP_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] OP_ONE   = WIDTH'(1);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [EW-1:0]    ERR_ZERO = {EW{1'b0}};
  localparam logic [EW-1:0]    ERR_ONE  = EW'(1);
  localparam logic [EW-1:0]    ERR_MAX  = {EW{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET_MUL = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT      = 3'd3,
    ST_CHECK     = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic             run_r;
  logic             run_rise_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] op_a_s, op_b_s;
  logic [WIDTH-1:0] fe_a_s, fe_b_s;
  logic [EW-1:0]    err_s;
  logic             fe_flag_r, fe_flag_s;
  logic             mismatch_s;

  function automatic logic [PW-1:0] ref_product(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    a_ext = PW'(a);
    b_ext = PW'(b);
    return a_ext * b_ext;
  endfunction

  assign run_rise_s = run & ~run_r;
  assign mismatch_s = (prod != ref_product(op_a, op_b));

  // Next-state and next-datapath logic for the sweep FSM.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    op_a_s    = op_a;
    op_b_s    = op_b;
    err_s     = err_count;
    fe_flag_s = fe_flag_r;
    fe_a_s    = first_err_a;
    fe_b_s    = first_err_b;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (run_rise_s) begin
          state_s   = ST_RESET_MUL;
          op_a_s    = OP_ZERO;
          op_b_s    = OP_ZERO;
          err_s     = ERR_ZERO;
          fe_flag_s = 1'b0;
          fe_a_s    = OP_ZERO;
          fe_b_s    = OP_ZERO;
        end else begin
          state_s = state_r;
        end
      end
      ST_RESET_MUL: state_s = ST_START;
      ST_START: begin
        state_s = ST_WAIT;
        cnt_s   = CNT_LOAD;
      end
      ST_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_CHECK;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_CHECK: begin
        if (mismatch_s) begin
          // saturating guard: the count can never reach ERR_MAX for a full sweep
          if (err_count != ERR_MAX) begin
            err_s = err_count + ERR_ONE;
          end else begin
            err_s = err_count;
          end
          if (!fe_flag_r) begin
            fe_flag_s = 1'b1;
            fe_a_s    = op_a;
            fe_b_s    = op_b;
          end else begin
            fe_flag_s = fe_flag_r;
          end
        end else begin
          err_s = err_count;
        end
        // last pair keeps (max,max) on the operand outputs
        if ((op_a == OP_MAX) && (op_b == OP_MAX)) begin
          state_s = ST_DONE;
        end else if (op_a != OP_MAX) begin
          state_s = ST_RESET_MUL;
          op_a_s  = op_a + OP_ONE;
        end else begin
          state_s = ST_RESET_MUL;
          op_a_s  = OP_ZERO;
          op_b_s  = op_b + OP_ONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state, run edge history and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      run_r   <= 1'b0;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      run_r   <= run;
      cnt_r   <= cnt_s;
    end
  end

  // Registered outputs decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_rst     <= 1'b1;
      mul_start   <= 1'b0;
      op_a        <= OP_ZERO;
      op_b        <= OP_ZERO;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= ERR_ZERO;
      fe_flag_r   <= 1'b0;
      first_err_a <= OP_ZERO;
      first_err_b <= OP_ZERO;
    end else begin
      mul_rst     <= (state_s == ST_IDLE) || (state_s == ST_RESET_MUL) || (state_s == ST_DONE);
      mul_start   <= (state_s == ST_START);
      op_a        <= op_a_s;
      op_b        <= op_b_s;
      busy        <= (state_s == ST_RESET_MUL) || (state_s == ST_START) ||
                     (state_s == ST_WAIT) || (state_s == ST_CHECK);
      done        <= (state_s == ST_DONE);
      pass        <= (state_s == ST_DONE) && (err_s == ERR_ZERO);
      err_count   <= err_s;
      fe_flag_r   <= fe_flag_s;
      first_err_a <= fe_a_s;
      first_err_b <= fe_b_s;
    end
  end

endmodule

// File: tb/tb_mult_sweep_sequencer.sv
// Bench for mult_sweep_sequencer: behavioural multiplier models with injectable
// faults drive two instances (default wait and a too-short wait).
`timescale 1ns/1ps
module tb_mult_sweep_sequencer;

  localparam int W           = 4;
  localparam int LAT         = 10;
  localparam int WAIT_MAIN   = 24;
  localparam int WAIT_SHORT  = 2;
  localparam int VEC         = 256;
  localparam int SWEEP_MAIN  = VEC * (WAIT_MAIN + 3);
  localparam int SWEEP_SHORT = VEC * (WAIT_SHORT + 3);

  logic         clk, rst, run, run2;
  logic [7:0]   prod, prod2;
  logic         mul_rst, mul_start, busy, done, pass;
  logic         mul_rst2, mul_start2, busy2, done2, pass2;
  logic [W-1:0] op_a, op_b, fe_a, fe_b, op_a2, op_b2, fe_a2, fe_b2;
  logic [8:0]   err_count, err_count2;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   fault_mode = 0;
  int   flip_mask [VEC];
  int   cyc = 0;
  bit   log_en = 1'b0;
  bit   st_en  = 1'b0;
  int   st_pulses = 0;
  int   st_wide   = 0;
  logic st_prev   = 1'b0;
  logic [7:0] vec_q [$];

  mult_sweep_sequencer #(.WIDTH(W), .WAIT_CYCLES(WAIT_MAIN)) dut (
    .clk(clk), .rst(rst), .run(run), .prod(prod),
    .mul_rst(mul_rst), .mul_start(mul_start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_a(fe_a), .first_err_b(fe_b));

  mult_sweep_sequencer #(.WIDTH(W), .WAIT_CYCLES(WAIT_SHORT)) dut_short (
    .clk(clk), .rst(rst), .run(run2), .prod(prod2),
    .mul_rst(mul_rst2), .mul_start(mul_start2), .op_a(op_a2), .op_b(op_b2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .first_err_a(fe_a2), .first_err_b(fe_b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier output under a given fault mode (0 ideal).
  function automatic int model_prod(input int a, input int b, input int mode);
    int p;
    p = a * b;
    case (mode)
      1:       if (a == 3 && b == 5) p = 0;
      2:       p = p & ~1;
      3:       p = p ^ flip_mask[b * 16 + a];
      default: p = a * b;
    endcase
    return p;
  endfunction

  // Behavioural multiplier with LAT-cycle latency, cleared by mul_rst.
  int pend, tmr, cap_a, cap_b, pend2, tmr2, cap_a2, cap_b2;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod <= 8'd0; pend <= 0; tmr <= 0;
    end else if (mul_rst) begin
      prod <= 8'd0; pend <= 0;
    end else if (mul_start) begin
      pend <= 1; tmr <= LAT - 1; cap_a <= op_a; cap_b <= op_b;
    end else if (pend != 0) begin
      if (tmr == 0) begin
        prod <= 8'(model_prod(cap_a, cap_b, fault_mode)); pend <= 0;
      end else tmr <= tmr - 1;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod2 <= 8'd0; pend2 <= 0; tmr2 <= 0;
    end else if (mul_rst2) begin
      prod2 <= 8'd0; pend2 <= 0;
    end else if (mul_start2) begin
      pend2 <= 1; tmr2 <= LAT - 1; cap_a2 <= op_a2; cap_b2 <= op_b2;
    end else if (pend2 != 0) begin
      if (tmr2 == 0) begin
        prod2 <= 8'(model_prod(cap_a2, cap_b2, 0)); pend2 <= 0;
      end else tmr2 <= tmr2 - 1;
    end
  end

  always @(posedge clk) begin
    if (log_en && mul_start) vec_q.push_back({op_b, op_a});
    if (st_en && mul_start2 && !st_prev) st_pulses <= st_pulses + 1;
    if (st_en && mul_start2 && st_prev)  st_wide   <= st_wide + 1;
    st_prev <= mul_start2;
  end

  // Reference: errors, first failing pair over a sweep in A-inner order.
  task automatic compute_expected(input int mode, input int wait_cycles, input int n_vec,
                                  output int exp_err, output int exp_fa, output int exp_fb);
    int got;
    exp_err = 0; exp_fa = 0; exp_fb = 0;
    for (int i = 0; i < n_vec; i++) begin
      got = (LAT <= wait_cycles) ? model_prod(i % 16, i / 16, mode) : 0;
      if (got != (i % 16) * (i / 16)) begin
        if (exp_err == 0) begin exp_fa = i % 16; exp_fb = i / 16; end
        exp_err++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; run = 1'b0; run2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic check_reset_values(input string name);
    n_tests++;
    if ({mul_rst, mul_start, op_a, op_b, busy, done, pass, err_count, fe_a, fe_b} !==
        {1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 9'd0, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL %s: mul_rst=%b start=%b op=(%0d,%0d) busy=%b done=%b pass=%b err=%0d fe=(%0d,%0d), required 1 0 (0,0) 0 0 0 0 (0,0)",
               name, mul_rst, mul_start, op_a, op_b, busy, done, pass, err_count, fe_a, fe_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b0; run2 = 1'b0;
    #23;
    check_reset_values("reset");
    n_tests++;
    if ({mul_rst2, mul_start2, busy2, done2, err_count2} !== {1'b1, 1'b0, 1'b0, 1'b0, 9'd0}) begin
      n_fail++;
      $display("FAIL reset_short: mul_rst=%b start=%b busy=%b done=%b err=%0d, required 1 0 0 0 0",
               mul_rst2, mul_start2, busy2, done2, err_count2);
    end
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // One full sweep on the main instance with exact done timing.
  task automatic sweep_check(input string name, input int mode);
    int exp_err, exp_fa, exp_fb;
    fault_mode = mode;
    compute_expected(mode, WAIT_MAIN, VEC, exp_err, exp_fa, exp_fb);
    @(negedge clk) run = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || op_a !== 4'd0 || op_b !== 4'd0 || err_count !== 9'd0) begin
      n_fail++;
      $display("FAIL %s_start: busy=%b done=%b pass=%b op=(%0d,%0d) err=%0d, required 1 0 0 (0,0) 0",
               name, busy, done, pass, op_a, op_b, err_count);
    end
    repeat (SWEEP_MAIN - 1) @(posedge clk);
    #1;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_early: done=%b busy=%b one cycle before end, required 0 1", name, done, busy);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== (exp_err == 0) || err_count !== 9'(exp_err)) begin
      n_fail++;
      $display("FAIL %s_end: done=%b busy=%b pass=%b err=%0d, required 1 0 %b %0d",
               name, done, busy, pass, err_count, (exp_err == 0), exp_err);
    end
    n_tests++;
    if (fe_a !== 4'(exp_fa) || fe_b !== 4'(exp_fb) || op_a !== 4'd15 || op_b !== 4'd15 || mul_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_first: fe=(%0d,%0d) op=(%0d,%0d) mul_rst=%b, required fe=(%0d,%0d) op=(15,15) mul_rst=1",
               name, fe_a, fe_b, op_a, op_b, mul_rst, exp_fa, exp_fb);
    end
    @(negedge clk) run = 1'b0;
  endtask

  task automatic test_vector_order();
    int bad;
    vec_q.delete();
    log_en = 1'b1;
    sweep_check("ideal", 0);
    log_en = 1'b0;
    n_tests++;
    if (vec_q.size() != VEC) begin
      n_fail++;
      $display("FAIL order_count: %0d start pulses, required %0d", vec_q.size(), VEC);
    end
    bad = -1;
    for (int i = 0; i < vec_q.size() && i < VEC; i++)
      if (bad < 0 && vec_q[i] != 8'(((i / 16) << 4) | (i % 16))) bad = i;
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL order_seq: vector %0d was (a=%0d,b=%0d), required (a=%0d,b=%0d)",
               bad, vec_q[bad][3:0], vec_q[bad][7:4], bad % 16, bad / 16);
    end
  endtask

  task automatic test_random_faults();
    int n, idx;
    for (int i = 0; i < VEC; i++) flip_mask[i] = 0;
    n = $urandom_range(3, 12);
    for (int k = 0; k < n; k++) begin
      idx = $urandom_range(0, VEC - 1);
      flip_mask[idx] = $urandom_range(1, 255);
    end
    sweep_check("random", 3);
  endtask

  task automatic test_reset_abort();
    int exp_pre, fa, fb;
    bit found;
    do_reset();
    fault_mode = 2;
    compute_expected(2, WAIT_MAIN, 100, exp_pre, fa, fb);
    @(negedge clk) run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < SWEEP_MAIN && !found; i++) begin
      @(negedge clk);
      if (op_a == 4'd4 && op_b == 4'd6 && busy) found = 1'b1;
    end
    n_tests++;
    if (!found || err_count !== 9'(exp_pre)) begin
      n_fail++;
      $display("FAIL abort_reach: found=%b err=%0d at vector 100, required found=1 err=%0d", found, err_count, exp_pre);
    end
    #2 rst = 1'b0;
    #1 check_reset_values("abort_reset");
    @(negedge clk) begin rst = 1'b1; run = 1'b0; end
    repeat (2) @(negedge clk);
    sweep_check("restart", 1);
  endtask

  task automatic test_run_ignored();
    int exp_err, fa, fb, t0;
    do_reset();
    fault_mode = 1;
    compute_expected(1, WAIT_MAIN, VEC, exp_err, fa, fb);
    @(negedge clk) run = 1'b1;
    @(posedge clk); #1 t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(200, 1200)) @(negedge clk);
      run = 1'b0;
      @(negedge clk) run = 1'b1;
    end
    while (cyc != t0 + SWEEP_MAIN - 1) begin @(posedge clk); #1; end
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_edges_early: done=%b before end, required 0", done);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b1 || err_count !== 9'(exp_err) || fe_a !== 4'(fa) || fe_b !== 4'(fb)) begin
      n_fail++;
      $display("FAIL busy_edges_end: done=%b err=%0d fe=(%0d,%0d), required 1 %0d (%0d,%0d)",
               done, err_count, fe_a, fe_b, exp_err, fa, fb);
    end
    repeat (50) @(posedge clk);
    #1;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b0 || err_count !== 9'(exp_err)) begin
      n_fail++;
      $display("FAIL run_held: done=%b busy=%b pass=%b err=%0d, required 1 0 0 %0d", done, busy, pass, err_count, exp_err);
    end
    @(negedge clk) run = 1'b0;
    @(negedge clk) run = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b1 || pass !== 1'b0 || err_count !== 9'd0 || op_a !== 4'd0 || op_b !== 4'd0) begin
      n_fail++;
      $display("FAIL rerun: done=%b busy=%b pass=%b err=%0d op=(%0d,%0d), required 0 1 0 0 (0,0)",
               done, busy, pass, err_count, op_a, op_b);
    end
  endtask

  task automatic test_short_wait();
    int exp_err, fa, fb;
    do_reset();
    compute_expected(0, WAIT_SHORT, VEC, exp_err, fa, fb);
    st_en = 1'b1;
    @(negedge clk) run2 = 1'b1;
    @(posedge clk);
    repeat (SWEEP_SHORT - 1) @(posedge clk);
    #1;
    n_tests++;
    if (done2 !== 1'b0) begin
      n_fail++;
      $display("FAIL short_early: done=%b, required 0", done2);
    end
    @(posedge clk); #1;
    st_en = 1'b0;
    n_tests++;
    if (done2 !== 1'b1 || pass2 !== 1'b0 || err_count2 !== 9'(exp_err) || fe_a2 !== 4'(fa) || fe_b2 !== 4'(fb)) begin
      n_fail++;
      $display("FAIL short_end: done=%b pass=%b err=%0d fe=(%0d,%0d), required 1 0 %0d (%0d,%0d)",
               done2, pass2, err_count2, fe_a2, fe_b2, exp_err, fa, fb);
    end
    n_tests++;
    if (st_pulses != VEC || st_wide != 0) begin
      n_fail++;
      $display("FAIL short_start_width: pulses=%0d wide_cycles=%0d, required %0d 0", st_pulses, st_wide, VEC);
    end
    @(negedge clk) run2 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vector_order();
    sweep_check("single_fault", 1);
    sweep_check("stuck_bit0", 2);
    test_random_faults();
    test_reset_abort();
    test_run_ignored();
    test_short_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
